// File: rtl/axi_burst_write_responder_if.sv
// AXI3 write-channel signal bundle (AW, W, B) between a burst write master and the responder.
interface axi_burst_write_responder_if;
  logic [31:0] s_axi_awaddr;
  logic [3:0]  s_axi_awlen;
  logic [2:0]  s_axi_awsize;
  logic [1:0]  s_axi_awburst;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [63:0] s_axi_wdata;
  logic [7:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wlast;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;

  modport master (
    output s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
    output s_axi_wdata, s_axi_wstrb, s_axi_wvalid, s_axi_wlast, s_axi_bready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid
  );

  modport slave (
    input  s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid, s_axi_wlast, s_axi_bready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid
  );
endinterface

// File: rtl/axi_burst_write_responder.sv
// AXI3 64-bit INCR write subordinate: stores beats into a byte-strobed memory and
// returns one B response per burst, with a debug read port and completion counters.
module axi_burst_write_responder #(
  parameter int unsigned MEM_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  axi_burst_write_responder_if.slave   axi,
  input  logic                         stall_w,
  input  logic [$clog2(MEM_WORDS)-1:0] dbg_addr,
  output logic [63:0]                  dbg_rdata,
  output logic [15:0]                  burst_count,
  output logic [1:0]                   last_bresp
);
  localparam int unsigned IW = $clog2(MEM_WORDS);
  localparam int unsigned XW = IW + 5;
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 3;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_e;
  state_e state_q, state_d;

  logic [XW-1:0] start_q, start_d;
  logic [3:0]    len_q, len_d, beat_q, beat_d;
  logic          aw_err_q, aw_err_d, slverr_q, slverr_d, decerr_q, decerr_d;
  logic          awready_q, bvalid_q;
  logic [1:0]    bresp_q, bresp_d, last_q;
  logic [15:0]   count_q;
  logic [63:0]   mem_q [MEM_WORDS];
  logic [63:0]   dbg_q;

  logic          aw_hs, w_hs, b_hs, final_beat;
  logic [31:0]   aw_off;
  logic          aw_slv, aw_dec;
  logic [XW-1:0] wr_idx;
  logic          wr_idx_oob;
  logic          wready_c, wr_en_c;

  assign aw_hs      = (state_q == IDLE) & awready_q & axi.s_axi_awvalid;
  assign w_hs       = wready_c & axi.s_axi_wvalid;
  assign b_hs       = (state_q == RESP) & bvalid_q & axi.s_axi_bready;
  assign final_beat = (beat_q == len_q);

  // Address decode at the AW handshake; low three address bits are ignored
  assign aw_off = axi.s_axi_awaddr - BASE_ADDR;
  assign aw_slv = (axi.s_axi_awsize != 3'b011) | (axi.s_axi_awburst != 2'b01);
  assign aw_dec = (axi.s_axi_awaddr < BASE_ADDR) | ({1'b0, aw_off} >= MEM_BYTES);

  // Index is kept wide so a burst running past the end is seen, never wrapped
  assign wr_idx     = start_q + XW'(beat_q);
  assign wr_idx_oob = (wr_idx >= XW'(MEM_WORDS));

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (aw_hs) state_d = DATA;
      DATA:    if (w_hs && final_beat) state_d = RESP;
      RESP:    if (b_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wready_c = 1'b0;
    wr_en_c  = 1'b0;
    if (state_q == DATA) begin
      wready_c = ~stall_w;
      wr_en_c  = w_hs & aresetn & ~aw_err_q & ~wr_idx_oob;
    end
  end

  // Burst bookkeeping; error flags accumulate and collapse into bresp on the final beat
  always_comb begin
    start_d  = start_q;
    len_d    = len_q;
    beat_d   = beat_q;
    aw_err_d = aw_err_q;
    slverr_d = slverr_q;
    decerr_d = decerr_q;
    bresp_d  = bresp_q;
    if (aw_hs) begin
      start_d  = XW'(aw_off[IW+2:3]);
      len_d    = axi.s_axi_awlen;
      beat_d   = 4'd0;
      aw_err_d = aw_slv | aw_dec;
      slverr_d = aw_slv;
      decerr_d = aw_dec;
    end else if (w_hs) begin
      beat_d   = beat_q + 4'd1;
      decerr_d = decerr_q | wr_idx_oob;
      slverr_d = slverr_q | (axi.s_axi_wlast != final_beat);
      if (final_beat) begin
        bresp_d = decerr_d ? RESP_DECERR : (slverr_d ? RESP_SLVERR : RESP_OKAY);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      start_q   <= '0;
      len_q     <= 4'd0;
      beat_q    <= 4'd0;
      aw_err_q  <= 1'b0;
      slverr_q  <= 1'b0;
      decerr_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      count_q   <= 16'd0;
      last_q    <= RESP_OKAY;
    end else begin
      start_q   <= start_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      aw_err_q  <= aw_err_d;
      slverr_q  <= slverr_d;
      decerr_q  <= decerr_d;
      bresp_q   <= bresp_d;
      awready_q <= (state_d == IDLE);
      bvalid_q  <= (state_d == RESP);
      if (b_hs) begin
        count_q <= count_q + 16'd1;
        last_q  <= bresp_q;
      end
    end
  end

  // Storage is deliberately not reset; debug read sees the pre-write value on a collision
  always_ff @(posedge aclk) begin
    if (wr_en_c) begin
      for (int i = 0; i < 8; i++) begin
        if (axi.s_axi_wstrb[i]) mem_q[wr_idx[IW-1:0]][8*i +: 8] <= axi.s_axi_wdata[8*i +: 8];
      end
    end
    dbg_q <= mem_q[dbg_addr];
  end

  assign axi.s_axi_awready = awready_q;
  assign axi.s_axi_wready  = wready_c;
  assign axi.s_axi_bvalid  = bvalid_q;
  assign axi.s_axi_bresp   = bresp_q;
  assign dbg_rdata         = dbg_q;
  assign burst_count       = count_q;
  assign last_bresp        = last_q;
endmodule

// File: doc/axi_burst_write_responder.md
Name: axi_burst_write_responder

Overview:
AXI3 write-channel subordinate that terminates 64-bit INCR write bursts from the team's burst write generator. It stores accepted beats into an internal byte-strobed memory and returns a per-burst write response. A debug read port and status counters let the VIP/checker bench compare stored data against what was sent. An optional W-channel stall input lets the bench exercise master backpressure.

Parameters:
MEM_WORDS, 256, depth of internal memory in 64-bit words (power of 2)
BASE_ADDR, 32'h0000_0000, byte address mapped to memory word 0 (8-byte aligned)

Ports:
aclk  in  1  clock, all logic on rising edge
aresetn  in  1  synchronous active-low reset
s_axi_awaddr  in  32  burst start byte address
s_axi_awlen  in  4  beats minus 1 (0..15)
s_axi_awsize  in  3  beat size; only 3'b011 legal
s_axi_awburst  in  2  burst type; only 2'b01 (INCR) legal
s_axi_awvalid  in  1  address valid
s_axi_awready  out  1  address ready
s_axi_wdata  in  64  beat data
s_axi_wstrb  in  8  byte enables
s_axi_wvalid  in  1  data valid
s_axi_wlast  in  1  last beat marker
s_axi_wready  out  1  data ready
s_axi_bresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
s_axi_bvalid  out  1  response valid
s_axi_bready  in  1  response ready
stall_w  in  1  when 1, wready forced 0 this cycle
dbg_addr  in  log2(MEM_WORDS)  debug read word index
dbg_rdata  out  64  mem[dbg_addr], 1-cycle latency
burst_count  out  16  completed B handshakes, wraps at 65535->0
last_bresp  out  2  bresp of most recent completed burst

Behaviour:
- Reset (aresetn=0 at edge): state IDLE; awready, wready, bvalid = 0; bresp, last_bresp = 00; burst_count = 0; beat counter, latched addr/len/error cleared. Memory contents NOT reset. dbg_rdata undefined until first read after reset.
- Reset mid-burst: burst abandoned, no B response; beats already written remain in memory.
- FSM states: IDLE, DATA, RESP.
- IDLE: awready=1 (registered; first 1 is the cycle after reset release). On awvalid&awready: latch awaddr, awlen; compute error flags; beat_cnt=0; go DATA; awready=0 next cycle.
- Address error flags at AW handshake: awsize!=3'b011 or awburst!=2'b01 -> SLVERR. Start offset (awaddr-BASE_ADDR) >= MEM_WORDS*8 or awaddr<BASE_ADDR -> DECERR. awaddr[2:0] ignored (aligned down).
- DATA: wready = ~stall_w (combinational). On wvalid&wready: word index = start_word + beat_cnt. If index < MEM_WORDS and no address error, write bytes of wdata where wstrb bit=1 (byte i = wdata[8i+7:8i]); else discard the beat. An index >= MEM_WORDS sets DECERR (no wrap into word 0). beat_cnt increments.
- Burst end: on the accepted beat with beat_cnt==latched awlen -> RESP. wlast=1 on any earlier beat, or wlast=0 on the final beat -> SLVERR. Length is always taken from awlen, never from wlast.
- Response priority: DECERR > SLVERR > OKAY.
- RESP: bvalid=1 and bresp held stable until bready. On bvalid&bready: burst_count+=1, last_bresp=bresp, go IDLE; awready=1 the following cycle.
- bready held high before bvalid: handshake completes on the first bvalid cycle.
- Throughput: one beat/cycle with stall_w=0. Minimum burst turnaround = AW cycle + (awlen+1) beats + 1 B cycle.
- Only one outstanding burst; AW accepted only in IDLE. W beats presented while in IDLE are not accepted (wready=0).
- Debug port: dbg_rdata registered from mem[dbg_addr] every cycle. A same-cycle write to that word returns the old value.

Test Plan:
- Single beat: awaddr=0x10, awlen=0, wdata=0x1122334455667788, wstrb=FF, wlast=1 -> bresp=00, dbg_addr=2 reads 0x1122334455667788, burst_count=1.
- 4-beat INCR at 0x100, data 0xA0..0xA3, beat 2 wstrb=0x0F over prior 0xFFFF_FFFF_FFFF_FFFF -> words 32..35 = A0,A1,0xFFFFFFFF000000A2,A3; bresp=00.
- Backpressure: 16-beat burst with stall_w toggling every other cycle and bready delayed 5 cycles -> all 16 words stored, bvalid held with bresp=00 for 5 cycles, single increment of burst_count.
- Out of range: awaddr=BASE+MEM_WORDS*8-16, awlen=3 -> first 2 beats written, last 2 discarded, bresp=11.
- Protocol errors: awburst=00 -> bresp=10, memory unchanged; legal INCR awlen=3 with wlast on beat 1 -> all 4 beats written, bresp=10.
- Reset mid-burst after 2 of 4 beats -> awready=1 the cycle after release, no bvalid, words 0..1 retained, burst_count=0.
